cache_controller: RTL and testbench

- Sequencing FSM for the direct-mapped, write-through, no-write-allocate data cache behind the single-cycle RISC-V core.
- Takes MemRead/MemWrite from the control unit and the tag-compare hit from the cache array.
- Drives the core stall, cache word/tag write strobes and a request/ready handshake to multi-cycle main memory; refills a whole line on a read miss.
- Keeps saturating read-hit/read-miss statistics counters.

---
 rtl/cache_controller_if.sv | 34 +++
 rtl/cache_controller.sv | 129 ++++++++++++
 tb/tb_cache_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Core/cache-array/memory signal bundle for the data cache sequencer.
// The controller uses the master view; the core-side environment uses slave.
interface cache_controller_if #(
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  logic             MemRead;
  logic             MemWrite;
  logic             hit;
  logic             mem_ready;
  logic             stall;
  logic             cache_we;
  logic             refill_sel;
  logic [OFF_W-1:0] refill_offset;
  logic             tag_we;
  logic             mem_req;
  logic             mem_we;
  logic [CNT_W-1:0] read_hits;
  logic [CNT_W-1:0] read_misses;

  modport master (
    input  MemRead, MemWrite, hit, mem_ready,
    output stall, cache_we, refill_sel, refill_offset, tag_we,
           mem_req, mem_we, read_hits, read_misses
  );

  modport slave (
    output MemRead, MemWrite, hit, mem_ready,
    input  stall, cache_we, refill_sel, refill_offset, tag_we,
           mem_req, mem_we, read_hits, read_misses
  );
endinterface

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a whole line word by word; stores always go to memory.
module cache_controller #(
  parameter int BLOCK_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_controller_if.master   bus
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, WRITE_DONE} state_t;

  state_t           state;
  logic [OFF_W-1:0] refill_offset;
  logic             just_filled;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             refill_sel_q;
  logic [CNT_W-1:0] read_hits_q;
  logic [CNT_W-1:0] read_misses_q;
  logic             is_store;
  logic             is_load;
  logic             last_word;
  logic             stall_c;
  logic             cache_we_c;
  logic             tag_we_c;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // A simultaneous MemRead/MemWrite is handled as a store.
  assign is_store  = bus.MemWrite;
  assign is_load   = bus.MemRead & ~bus.MemWrite;
  assign last_word = (refill_offset == LAST_OFF);

  // Same-cycle strobes: stall on detection and data-array writes on each refill word.
  always_comb begin
    stall_c    = 1'b0;
    cache_we_c = 1'b0;
    tag_we_c   = 1'b0;
    case (state)
      IDLE: begin
        stall_c    = is_store | (is_load & ~bus.hit);
        cache_we_c = is_store & bus.hit;
      end
      REFILL: begin
        stall_c    = 1'b1;
        cache_we_c = bus.mem_ready;
        tag_we_c   = bus.mem_ready & last_word;
      end
      WRITE_MEM: stall_c = 1'b1;
      default: ;
    endcase
  end

  // Main FSM: state, refill index, registered memory handshake and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      refill_offset <= '0;
      just_filled   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      refill_sel_q  <= 1'b0;
      read_hits_q   <= '0;
      read_misses_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The load that follows a refill is only allowed to skip the hit count once.
          just_filled <= 1'b0;
          if (is_store) begin
            state     <= WRITE_MEM;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (is_load && !bus.hit) begin
            read_misses_q <= sat_inc(read_misses_q);
            refill_offset <= '0;
            state         <= REFILL;
            mem_req_q     <= 1'b1;
            refill_sel_q  <= 1'b1;
          end else if (is_load && !just_filled) begin
            read_hits_q <= sat_inc(read_hits_q);
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            if (last_word) begin
              refill_offset <= '0;
              just_filled   <= 1'b1;
              state         <= IDLE;
              mem_req_q     <= 1'b0;
              refill_sel_q  <= 1'b0;
            end else begin
              refill_offset <= refill_offset + OFF_ONE;
            end
          end
        end
        WRITE_MEM: begin
          if (bus.mem_ready) begin
            state     <= WRITE_DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        // Store retires here; a still-held MemWrite is the same store.
        WRITE_DONE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign bus.stall         = stall_c;
  assign bus.cache_we      = cache_we_c;
  assign bus.tag_we        = tag_we_c;
  assign bus.refill_sel    = refill_sel_q;
  assign bus.refill_offset = refill_offset;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.read_hits     = read_hits_q;
  assign bus.read_misses   = read_misses_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with BLOCK_WORDS=4 and CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
module tb_cache_controller;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   req_cycles;

  always #5 clk = ~clk;

  cache_controller_if #(.BLOCK_WORDS(4), .CNT_W(4)) bus ();

  cache_controller #(.BLOCK_WORDS(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    fails++;
    $error("FAIL timeout: stimulus did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset         = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.hit       = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_hits", bus.read_hits, 0);
    chk("rst_misses", bus.read_misses, 0);
    chk("rst_offset", bus.refill_offset, 0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Three consecutive read hits
    bus.MemRead = 1'b1;
    bus.hit     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("hit_stall", bus.stall, 0);
      chk("hit_mem_req", bus.mem_req, 0);
      next_cycle();
    end
    chk("hit_count3", bus.read_hits, 3);

    // Read miss, memory ready every other cycle
    bus.hit = 1'b0;
    #2;
    chk("miss_detect_stall", bus.stall, 1);
    chk("miss_detect_req", bus.mem_req, 0);
    next_cycle();
    chk("miss_count", bus.read_misses, 1);
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'b0;
      #2;
      chk("refill_wait_stall", bus.stall, 1);
      chk("refill_wait_req", bus.mem_req, 1);
      chk("refill_wait_cwe", bus.cache_we, 0);
      chk("refill_sel", bus.refill_sel, 1);
      next_cycle();
      bus.mem_ready = 1'b1;
      #2;
      chk("refill_cwe", bus.cache_we, 1);
      chk("refill_offset", bus.refill_offset, k);
      chk("refill_mem_we", bus.mem_we, 0);
      chk("refill_tag_we", bus.tag_we, (k == 3) ? 1 : 0);
      next_cycle();
    end
    bus.mem_ready = 1'b0;
    bus.hit       = 1'b1;
    #2;
    chk("post_fill_stall", bus.stall, 0);
    chk("post_fill_req", bus.mem_req, 0);
    next_cycle();
    chk("post_fill_hits", bus.read_hits, 3);
    chk("post_fill_misses", bus.read_misses, 1);
    #2;
    next_cycle();
    chk("hit_after_fill", bus.read_hits, 4);

    // Store hit, memory ready on the third request cycle
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.hit      = 1'b1;
    #2;
    chk("st_detect_stall", bus.stall, 1);
    chk("st_detect_cwe", bus.cache_we, 1);
    chk("st_detect_sel", bus.refill_sel, 0);
    chk("st_detect_req", bus.mem_req, 0);
    next_cycle();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 2);
      #2;
      if (bus.mem_req && bus.mem_we) req_cycles++;
      chk("st_wait_cwe", bus.cache_we, 0);
      chk("st_wait_stall", bus.stall, 1);
      next_cycle();
    end
    chk("st_req_cycles", req_cycles, 3);
    bus.mem_ready = 1'b0;
    #2;
    chk("st_done_stall", bus.stall, 0);
    chk("st_done_req", bus.mem_req, 0);
    chk("st_done_cwe", bus.cache_we, 0);
    next_cycle();
    bus.MemWrite = 1'b0;
    bus.hit      = 1'b0;
    #2;
    chk("st_idle_req", bus.mem_req, 0);
    chk("st_idle_stall", bus.stall, 0);
    next_cycle();

    // Store miss with immediate memory ready
    bus.MemWrite  = 1'b1;
    bus.mem_ready = 1'b1;
    #2;
    chk("stm_stall0", bus.stall, 1);
    chk("stm_cwe0", bus.cache_we, 0);
    chk("stm_twe0", bus.tag_we, 0);
    next_cycle();
    #2;
    chk("stm_stall1", bus.stall, 1);
    chk("stm_req1", bus.mem_req, 1);
    chk("stm_we1", bus.mem_we, 1);
    chk("stm_cwe1", bus.cache_we, 0);
    chk("stm_twe1", bus.tag_we, 0);
    next_cycle();
    #2;
    chk("stm_stall2", bus.stall, 0);
    chk("stm_req2", bus.mem_req, 0);
    next_cycle();
    bus.MemWrite  = 1'b0;
    bus.mem_ready = 1'b0;
    next_cycle();

    // Reset asserted mid-refill at offset 2
    bus.MemRead = 1'b1;
    bus.hit     = 1'b0;
    next_cycle();
    bus.mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b0;
    #1;
    chk("pre_rst_offset", bus.refill_offset, 2);
    chk("pre_rst_req", bus.mem_req, 1);
    bus.MemRead = 1'b0;
    reset       = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_offset", bus.refill_offset, 0);
    chk("mid_rst_hits", bus.read_hits, 0);
    chk("mid_rst_misses", bus.read_misses, 0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    bus.MemRead = 1'b1;
    #2;
    chk("rerun_stall", bus.stall, 1);
    next_cycle();
    chk("rerun_offset", bus.refill_offset, 0);
    chk("rerun_req", bus.mem_req, 1);
    chk("rerun_misses", bus.read_misses, 1);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    bus.mem_ready = 1'b0;

    // Saturation: one uncounted post-fill load, then 20 counted hits
    bus.hit = 1'b1;
    for (int i = 0; i < 21; i++) next_cycle();
    chk("hits_saturated", bus.read_hits, 15);

    // MemRead and MemWrite together act as a store
    bus.MemWrite = 1'b1;
    bus.hit      = 1'b0;
    #2;
    chk("both_stall", bus.stall, 1);
    chk("both_cwe", bus.cache_we, 0);
    next_cycle();
    chk("both_mem_we", bus.mem_we, 1);
    chk("both_req", bus.mem_req, 1);
    chk("both_misses", bus.read_misses, 1);
    chk("both_sel", bus.refill_sel, 0);
    bus.mem_ready = 1'b1;
    next_cycle();
    #1;
    chk("both_done_stall", bus.stall, 0);
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.mem_ready = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
